// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage branch/jump resolution for a static
// predict-not-taken pipeline. Decides taken/not-taken, issues a one-cycle
// fetch redirect, holds flush for FLUSH_CYCLES cycles to squash wrong-path
// instructions, flags illegal branch encodings and keeps event counters.
module branch_resolve #(
  parameter int FLUSH_CYCLES = 2  // legal range 1..3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_valid,
  input  logic        is_jump,
  input  logic [2:0]  funct3,
  input  logic        br_eq,
  input  logic        br_gt,
  input  logic [31:0] target,
  input  logic        stall,
  output logic        br_sel,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        illegal_br,
  output logic [31:0] branch_cnt,
  output logic [31:0] taken_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Flush counter reloads with FLUSH_CYCLES-1 and counts down to 0, so the
  // FLUSH state lasts exactly FLUSH_CYCLES cycles.
  localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;

  logic eval;          // branch/jump is resolved this cycle
  logic illegal_type;  // funct3 010/011 on a conditional branch
  logic cond_taken;    // condition outcome for the conditional types
  logic legal_eval;
  logic taken_eval;

  // Comparator mode is a pure decode of the branch type (1 = unsigned).
  assign br_sel = funct3[1];

  // Flush is asserted for the whole time the FSM sits in FLUSH.
  assign flush = (state == FLUSH);

  // Evaluation qualification: only in IDLE, with a valid, non-stalled branch.
  assign eval         = (state == IDLE) && br_valid && !stall;
  assign illegal_type = !is_jump && (funct3[2:1] == 2'b01);
  assign legal_eval   = eval && !illegal_type;
  assign taken_eval   = legal_eval && (is_jump || cond_taken);

  // Decode the branch condition from the comparator flags.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cond_taken = 1'b0;
    case (funct3)
      3'b000:         cond_taken = br_eq;              // BEQ
      3'b001:         cond_taken = !br_eq;             // BNE
      3'b100, 3'b110: cond_taken = !br_eq && !br_gt;   // BLT / BLTU
      3'b101, 3'b111: cond_taken = br_eq || br_gt;     // BGE / BGEU
      default:        cond_taken = 1'b0;               // 010/011 illegal
    endcase
  end

  // FSM state and flush counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // FSM next-state: a taken evaluation enters FLUSH; FLUSH ignores
  // br_valid and stall and counts down back to IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (taken_eval) begin
          state_nxt = FLUSH;
          cnt_nxt   = CNT_INIT;
        end
      end
      FLUSH: begin
        if (cnt == 2'd0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 2'd0;
      end
    endcase
  end

  // Registered one-cycle pulses and the redirect target (held otherwise).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect    <= 1'b0;
      illegal_br  <= 1'b0;
      redirect_pc <= 32'd0;
    end else begin
      redirect   <= taken_eval;
      illegal_br <= eval && illegal_type;
      if (taken_eval) begin
        redirect_pc <= target & ~32'd1;
      end
    end
  end

  // Event counters; both wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt <= 32'd0;
      taken_cnt  <= 32'd0;
    end else begin
      if (legal_eval) begin
        branch_cnt <= branch_cnt + 32'd1;
      end
      if (taken_eval) begin
        taken_cnt <= taken_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: drives one FLUSH_CYCLES=2 and one FLUSH_CYCLES=3
// instance with identical stimulus and compares both against a
// cycle-level reference model (remaining-flush count per instance).
module tb_branch_resolve;

  localparam int FC[2] = '{2, 3};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_valid, is_jump, br_eq, br_gt, stall;
  logic [2:0]  funct3;
  logic [31:0] target;

  logic        w_br_sel[2];
  logic        w_redirect[2];
  logic [31:0] w_redirect_pc[2];
  logic        w_flush[2];
  logic        w_illegal[2];
  logic [31:0] w_bcnt[2];
  logic [31:0] w_tcnt[2];

  // Reference model state per instance
  int          m_rem[2];
  logic        m_redir[2];
  logic        m_ill[2];
  logic [31:0] m_pc[2];
  logic [31:0] m_bcnt[2];
  logic [31:0] m_tcnt[2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_resolve #(.FLUSH_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .is_jump(is_jump),
    .funct3(funct3), .br_eq(br_eq), .br_gt(br_gt), .target(target),
    .stall(stall), .br_sel(w_br_sel[0]), .redirect(w_redirect[0]),
    .redirect_pc(w_redirect_pc[0]), .flush(w_flush[0]),
    .illegal_br(w_illegal[0]), .branch_cnt(w_bcnt[0]), .taken_cnt(w_tcnt[0])
  );

  branch_resolve #(.FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .is_jump(is_jump),
    .funct3(funct3), .br_eq(br_eq), .br_gt(br_gt), .target(target),
    .stall(stall), .br_sel(w_br_sel[1]), .redirect(w_redirect[1]),
    .redirect_pc(w_redirect_pc[1]), .flush(w_flush[1]),
    .illegal_br(w_illegal[1]), .branch_cnt(w_bcnt[1]), .taken_cnt(w_tcnt[1])
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Branch rule table in terms of "less than" / "greater or equal".
  function automatic bit ref_taken(input bit j, input logic [2:0] f,
                                   input bit eq, input bit gt);
    bit lt;
    lt = !eq && !gt;
    if (j) return 1'b1;
    if (f == 3'd0) return eq;
    if (f == 3'd1) return !eq;
    if (f == 3'd4 || f == 3'd6) return lt;
    if (f == 3'd5 || f == 3'd7) return !lt;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_rem[i] = 0; m_redir[i] = 1'b0; m_ill[i] = 1'b0;
      m_pc[i] = 32'd0; m_bcnt[i] = 32'd0; m_tcnt[i] = 32'd0;
    end
  endtask

  // Advance the model by one rising edge using the current inputs.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      m_redir[i] = 1'b0;
      m_ill[i]   = 1'b0;
      if (m_rem[i] > 0) begin
        m_rem[i]--;
      end else if (br_valid && !stall) begin
        if (!is_jump && (funct3 == 3'd2 || funct3 == 3'd3)) begin
          m_ill[i] = 1'b1;
        end else begin
          m_bcnt[i] += 1;
          if (ref_taken(is_jump, funct3, br_eq, br_gt)) begin
            m_tcnt[i] += 1;
            m_redir[i] = 1'b1;
            m_pc[i]    = {target[31:1], 1'b0};
            m_rem[i]   = FC[i];
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("fc%0d_br_sel", FC[i]), 32'(w_br_sel[i]), 32'(funct3[1]));
      check($sformatf("fc%0d_redirect", FC[i]), 32'(w_redirect[i]), 32'(m_redir[i]));
      check($sformatf("fc%0d_redirect_pc", FC[i]), w_redirect_pc[i], m_pc[i]);
      check($sformatf("fc%0d_flush", FC[i]), 32'(w_flush[i]), 32'(m_rem[i] > 0));
      check($sformatf("fc%0d_illegal_br", FC[i]), 32'(w_illegal[i]), 32'(m_ill[i]));
      check($sformatf("fc%0d_branch_cnt", FC[i]), w_bcnt[i], m_bcnt[i]);
      check($sformatf("fc%0d_taken_cnt", FC[i]), w_tcnt[i], m_tcnt[i]);
    end
  endtask

  // One clock: drive at posedge+1, step model at the edge, compare at +1.
  task automatic cycle(input bit bv, input bit j, input logic [2:0] f,
                       input bit eq, input bit gt, input logic [31:0] tgt,
                       input bit st);
    br_valid = bv; is_jump = j; funct3 = f; br_eq = eq; br_gt = gt;
    target = tgt; stall = st;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  // Asynchronous reset asserted between edges, checked before any edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
    compare_all();
  endtask

  initial begin
    int hi_cnt;
    rst_n = 1'b0;
    br_valid = 1'b0; is_jump = 1'b0; funct3 = 3'd0; br_eq = 1'b0;
    br_gt = 1'b0; target = 32'd0; stall = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 compare_all();
    rst_n = 1'b1;

    // BEQ taken right after reset release
    cycle(1, 0, 3'b000, 1, 0, 32'h0000_0104, 0);
    check("beq_redirect", 32'(w_redirect[0]), 32'd1);
    check("beq_pc", w_redirect_pc[0], 32'h104);
    check("beq_flush1", 32'(w_flush[0]), 32'd1);
    check("beq_bcnt", w_bcnt[0], 32'd1);
    check("beq_tcnt", w_tcnt[0], 32'd1);
    idle(1);
    check("beq_redirect_off", 32'(w_redirect[0]), 32'd0);
    check("beq_flush2", 32'(w_flush[0]), 32'd1);
    idle(1);
    check("beq_flush_end", 32'(w_flush[0]), 32'd0);
    idle(2);

    // BLTU taken (unsigned compare), BGE not taken
    cycle(1, 0, 3'b110, 0, 0, 32'h0000_0200, 0);
    check("bltu_br_sel", 32'(w_br_sel[0]), 32'd1);
    check("bltu_redirect", 32'(w_redirect[0]), 32'd1);
    idle(3);
    cycle(1, 0, 3'b101, 0, 0, 32'h0000_0300, 0);
    check("bge_br_sel", 32'(w_br_sel[0]), 32'd0);
    check("bge_flush", 32'(w_flush[0]), 32'd0);
    check("bge_bcnt", w_bcnt[0], 32'd3);
    check("bge_tcnt", w_tcnt[0], 32'd2);

    // JAL followed by branches during flush, then one in first IDLE cycle
    cycle(1, 1, 3'b000, 0, 0, 32'h0000_2003, 0);
    cycle(1, 0, 3'b000, 1, 0, 32'h0000_0040, 0);
    cycle(1, 0, 3'b000, 1, 0, 32'h0000_0040, 0);
    check("jal_pc", w_redirect_pc[0], 32'h2002);
    check("jal_bcnt", w_bcnt[0], 32'd4);
    cycle(1, 0, 3'b000, 1, 0, 32'h0000_0040, 0);
    check("after_flush_pc", w_redirect_pc[0], 32'h40);
    check("after_flush_bcnt", w_bcnt[0], 32'd5);
    idle(4);

    // Illegal funct3
    cycle(1, 0, 3'b010, 1, 0, 32'h0000_0500, 0);
    check("ill_pulse", 32'(w_illegal[0]), 32'd1);
    check("ill_redirect", 32'(w_redirect[0]), 32'd0);
    check("ill_bcnt", w_bcnt[0], 32'd5);
    idle(1);
    check("ill_pulse_end", 32'(w_illegal[0]), 32'd0);

    // Reset during the second flush cycle
    cycle(1, 0, 3'b001, 0, 0, 32'h0000_0600, 0);
    idle(1);
    async_reset();
    check("rst_flush", 32'(w_flush[0]), 32'd0);
    check("rst_pc", w_redirect_pc[0], 32'd0);
    check("rst_bcnt", w_bcnt[0], 32'd0);
    cycle(1, 0, 3'b000, 1, 0, 32'h0000_0700, 0);
    check("post_rst_redirect", 32'(w_redirect[0]), 32'd1);
    idle(4);

    // Stalled branch held 4 cycles, evaluated on release (FLUSH_CYCLES=3)
    for (int k = 0; k < 4; k++) cycle(1, 0, 3'b000, 1, 0, 32'h0000_0800, 1);
    check("stall_no_eval", w_bcnt[1], 32'd1);
    cycle(1, 0, 3'b000, 1, 0, 32'h0000_0800, 0);
    check("stall_release_redirect", 32'(w_redirect[1]), 32'd1);
    hi_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (w_flush[1]) hi_cnt++;
      idle(1);
    end
    check("fc3_flush_len", 32'(hi_cnt), 32'd3);

    // Randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 1500; n++) begin
      bit          eq;
      logic [31:0] r;
      if ($urandom_range(0, 249) == 0) begin
        async_reset();
      end else begin
        eq = 1'($urandom % 2);
        r  = $urandom;
        cycle(1'($urandom_range(0, 99) < 45), 1'($urandom % 8 == 0),
              3'($urandom % 8), eq, eq ? 1'b0 : 1'($urandom % 2), r,
              1'($urandom % 4 == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
